// File: rtl/rep3_serial_tx.sv
// Repetition-code serial transmitter: shifts a word out MSB-first,
// each bit repeated REP chips, with frame and bit-start strobes.
module rep3_serial_tx #(
  parameter int DATA_W = 8,
  parameter int REP    = 3,
  parameter int GAP    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              tx_chip,
  output logic              tx_frame,
  output logic              tx_first,
  output logic              busy
);

  localparam int CW = (REP > 1) ? $clog2(REP) : 1;
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

  localparam logic [CW-1:0] CHIP_LAST = CW'(REP - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_W - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_GAP
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CW-1:0]     chip_q, chip_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [GW-1:0]     gap_q, gap_d;

  logic ready_q, ready_d;
  logic chip_out_q, chip_out_d;
  logic frame_q, frame_d;
  logic first_q, first_d;
  logic busy_q, busy_d;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    chip_d  = chip_q;
    bit_d   = bit_q;
    gap_d   = gap_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid && ready_q) begin
          state_d = ST_SEND;
          shift_d = in_data;
          chip_d  = '0;
          bit_d   = '0;
          gap_d   = '0;
        end
      end
      ST_SEND: begin
        if (chip_q == CHIP_LAST) begin
          chip_d  = '0;
          shift_d = shift_q << 1;
          if (bit_q == BIT_LAST) begin
            bit_d   = '0;
            state_d = (GAP > 0) ? ST_GAP : ST_IDLE;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          chip_d = chip_q + 1'b1;
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          gap_d   = '0;
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from next-state values so the first chip
  // shows up in the cycle right after the accepting edge.
  always_comb begin
    ready_d    = (state_d == ST_IDLE);
    frame_d    = (state_d == ST_SEND);
    chip_out_d = frame_d & shift_d[DATA_W-1];
    first_d    = frame_d && (chip_d == '0);
    busy_d     = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      chip_q     <= '0;
      bit_q      <= '0;
      gap_q      <= '0;
      ready_q    <= 1'b0;
      chip_out_q <= 1'b0;
      frame_q    <= 1'b0;
      first_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      chip_q     <= chip_d;
      bit_q      <= bit_d;
      gap_q      <= gap_d;
      ready_q    <= ready_d;
      chip_out_q <= chip_out_d;
      frame_q    <= frame_d;
      first_q    <= first_d;
      busy_q     <= busy_d;
    end
  end

  assign in_ready = ready_q;
  assign tx_chip  = chip_out_q;
  assign tx_frame = frame_q;
  assign tx_first = first_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_rep3_serial_tx.sv
// Bench for rep3_serial_tx: default instance plus a DATA_W=4/REP=5/GAP=0
// instance, chip stream checked against a queue of expected chips.
module tb_rep3_serial_tx;

  typedef struct packed {
    logic chip;
    logic first;
  } exp_t;

  typedef struct {
    logic [7:0]  d;
    logic [23:0] chips;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [7:0] a_data = '0;
  logic       a_valid = 1'b0;
  logic       a_ready, a_chip, a_frame, a_first, a_busy;

  logic [3:0] b_data = '0;
  logic       b_valid = 1'b0;
  logic       b_ready, b_chip, b_frame, b_first, b_busy;

  rep3_serial_tx a_dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(a_data), .in_valid(a_valid), .in_ready(a_ready),
    .tx_chip(a_chip), .tx_frame(a_frame), .tx_first(a_first),
    .busy(a_busy)
  );

  rep3_serial_tx #(.DATA_W(4), .REP(5), .GAP(0)) b_dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(b_data), .in_valid(b_valid), .in_ready(b_ready),
    .tx_chip(b_chip), .tx_frame(b_frame), .tx_first(b_first),
    .busy(b_busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;

  int fa_len = 0, fa_post = 0, fa_rdy = 0, fa_rdy_last = 0;
  int fa_start = 0, fa_prev = 0;
  bit abort_a = 0;
  int fb_len = 0, fb_start = 0, fb_prev = 0;

  always @(negedge clk) if (rst_n) begin
    if (a_frame) begin
      if (fa_len == 0) begin
        fa_prev = fa_start;
        fa_start = cyc;
        fa_rdy_last = fa_rdy;
        fa_rdy = 0;
      end
      fa_len++;
      if (qa.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL a_sb_empty: got chip %0b want none", a_chip);
      end else begin
        ea = qa.pop_front();
        chk("a_chip", 32'(a_chip), 32'(ea.chip));
        chk("a_first", 32'(a_first), 32'(ea.first));
      end
      fa_post = 0;
    end else begin
      if (a_ready) fa_rdy++;
      if (fa_post == 1) begin
        chk("a_idle_after_gap", {a_ready, a_busy}, 2'b10);
        fa_post = 0;
      end
      if (fa_len != 0) begin
        if (!abort_a) begin
          chk("a_frame_len", fa_len, 24);
          chk("a_gap_cycle", {a_ready, a_busy}, 2'b01);
          fa_post = 1;
        end
        fa_len = 0;
        abort_a = 0;
      end
    end
  end

  always @(negedge clk) if (rst_n) begin
    if (b_frame) begin
      if (fb_len == 0) begin
        fb_prev = fb_start;
        fb_start = cyc;
      end
      fb_len++;
      if (qb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL b_sb_empty: got chip %0b want none", b_chip);
      end else begin
        eb = qb.pop_front();
        chk("b_chip", 32'(b_chip), 32'(eb.chip));
        chk("b_first", 32'(b_first), 32'(eb.first));
      end
    end else if (fb_len != 0) begin
      chk("b_frame_len", fb_len, 20);
      chk("b_idle_after_frame", {b_ready, b_busy}, 2'b10);
      fb_len = 0;
    end
  end

  task automatic send_a(input logic [7:0] d, input logic [23:0] chips,
                        input bit hold);
    int n = 0;
    @(negedge clk);
    while (!a_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!a_ready) begin
      checks++;
      errors++;
      $display("FAIL a_ready_timeout: got 0 want 1");
      return;
    end
    a_data = d;
    a_valid = 1'b1;
    for (int i = 0; i < 24; i++)
      qa.push_back('{chip: chips[23-i], first: (i % 3) == 0});
    @(posedge clk);
    #1;
    if (!hold) a_valid = 1'b0;
    a_data = 8'hFF;
    chk("a_latency", {a_frame, a_first, a_busy, a_ready}, 4'b1110);
  endtask

  task automatic send_b(input logic [3:0] d, input logic [19:0] chips,
                        input bit hold);
    int n = 0;
    @(negedge clk);
    while (!b_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!b_ready) begin
      checks++;
      errors++;
      $display("FAIL b_ready_timeout: got 0 want 1");
      return;
    end
    b_data = d;
    b_valid = 1'b1;
    for (int i = 0; i < 20; i++)
      qb.push_back('{chip: chips[19-i], first: (i % 5) == 0});
    @(posedge clk);
    #1;
    if (!hold) b_valid = 1'b0;
    b_data = 4'hF;
    chk("b_latency", {b_frame, b_first, b_busy, b_ready}, 4'b1110);
  endtask

  task automatic wait_done(input bit is_b);
    int n = 0;
    while (n < 400 && (is_b ? (b_busy || qb.size() != 0)
                            : (a_busy || qa.size() != 0))) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got busy want idle (inst %0d)", is_b);
    end
    repeat (2) @(negedge clk);
  endtask

  vec_t tab[4];

  initial begin
    tab[0] = '{8'hA5, 24'b111000111000000111000111};
    tab[1] = '{8'h3C, 24'b000000111111111111000000};
    tab[2] = '{8'h5A, 24'b000111000111111000111000};
    tab[3] = '{8'hC3, 24'b111111000000000000111111};

    #23;
    chk("a_reset_outs", {a_ready, a_chip, a_frame, a_first, a_busy}, 5'b0);
    chk("b_reset_outs", {b_ready, b_chip, b_frame, b_first, b_busy}, 5'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("a_ready_after_reset", 32'(a_ready), 1);
    chk("b_ready_after_reset", 32'(b_ready), 1);

    repeat (100) begin
      @(negedge clk);
      chk("a_idle", {a_frame, a_chip, a_busy, a_ready}, 4'b0001);
      chk("b_idle", {b_frame, b_chip, b_busy, b_ready}, 4'b0001);
    end

    foreach (tab[i]) begin
      send_a(tab[i].d, tab[i].chips, 1'b0);
      wait_done(1'b0);
    end

    send_a(8'h00, 24'h000000, 1'b1);
    send_a(8'hFF, 24'hFFFFFF, 1'b0);
    wait_done(1'b0);
    chk("b2b_period", fa_start - fa_prev, 26);
    chk("b2b_ready_cycles", fa_rdy_last, 1);

    send_a(8'h81, 24'b111000000000000000000111, 1'b0);
    repeat (10) @(posedge clk);
    #2;
    abort_a = 1;
    rst_n = 1'b0;
    #1;
    chk("a_async_reset", {a_chip, a_frame, a_first, a_ready, a_busy}, 5'b0);
    chk("b_async_reset", {b_ready, b_busy}, 2'b0);
    qa.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("a_ready_after_abort", 32'(a_ready), 1);
    send_a(8'h01, 24'b000000000000000000000111, 1'b0);
    wait_done(1'b0);

    send_b(4'h9, 20'b11111000000000011111, 1'b1);
    send_b(4'h9, 20'b11111000000000011111, 1'b0);
    wait_done(1'b1);
    chk("b_period", fb_start - fb_prev, 21);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
